// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/single-port-RAM wrapper: serialises 2-bit command +
// 8-bit payload frames on MOSI (clk is the bit clock) and collects the 8-bit MISO reply of cmd 11.
module spi_ram_master #(
    parameter int RD_LATENCY = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEL,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_GUARD
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t      state_r;
    logic [9:0]  shift_r;
    logic [7:0]  rx_r;
    logic [3:0]  bit_cnt_r;
    logic [3:0]  cnt_r;
    logic        rd_frame_r;
    logic        ss_n_r;
    logic        mosi_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [7:0]  rsp_data_r;
    logic        busy_r;

    // Frame sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shift_r     <= 10'h000;
            rx_r        <= 8'h00;
            bit_cnt_r   <= 4'd0;
            cnt_r       <= 4'd0;
            rd_frame_r  <= 1'b0;
            ss_n_r      <= 1'b1;
            mosi_r      <= 1'b0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ss_n_r <= 1'b1;
                    mosi_r <= 1'b0;
                    if (req_valid && req_ready_r) begin
                        state_r     <= ST_START;
                        shift_r     <= {req_cmd, (req_cmd == 2'b11) ? 8'h00 : req_data};
                        rd_frame_r  <= (req_cmd == 2'b11);
                        rx_r        <= 8'h00;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        ss_n_r      <= 1'b0;
                    end else begin
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                ST_START: begin
                    // Path-select bit is cmd[1], still sitting at the top of the shifter.
                    state_r <= ST_SEL;
                    mosi_r  <= shift_r[9];
                end
                ST_SEL: begin
                    state_r   <= ST_SHIFT;
                    mosi_r    <= shift_r[9];
                    shift_r   <= {shift_r[8:0], 1'b0};
                    bit_cnt_r <= 4'd0;
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == 4'd9) begin
                        mosi_r    <= 1'b0;
                        bit_cnt_r <= 4'd0;
                        cnt_r     <= 4'd0;
                        if (!rd_frame_r) begin
                            state_r <= ST_GUARD;
                            ss_n_r  <= 1'b1;
                        end else if (RD_LATENCY == 0) begin
                            state_r <= ST_RECV;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        mosi_r    <= shift_r[9];
                        shift_r   <= {shift_r[8:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        state_r   <= ST_RECV;
                        cnt_r     <= 4'd0;
                        bit_cnt_r <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_RECV: begin
                    rx_r <= {rx_r[6:0], MISO};
                    if (bit_cnt_r == 4'd7) begin
                        rsp_data_r  <= {rx_r[6:0], MISO};
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_GUARD;
                        ss_n_r      <= 1'b1;
                        bit_cnt_r   <= 4'd0;
                        cnt_r       <= 4'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= 4'd0;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ss_n_r      <= 1'b1;
                    mosi_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;
    assign SS_n      = ss_n_r;
    assign MOSI      = mosi_r;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench: two masters (RD_LATENCY=1/GAP=2-less build and RD_LATENCY=0 build) against
// small behavioural wrapper models that decode MOSI frames and drive MISO replies.
module tb_spi_ram_master;

    localparam int RD_A  = 1;
    localparam int GAP_A = 1;
    localparam int RD_B  = 0;
    localparam int GAP_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_req_valid, a_req_ready, a_rsp_valid, a_busy, a_ss_n, a_mosi, a_miso;
    logic [1:0] a_req_cmd;
    logic [7:0] a_req_data, a_rsp_data;
    logic       b_req_valid, b_req_ready, b_rsp_valid, b_busy, b_ss_n, b_mosi, b_miso;
    logic [1:0] b_req_cmd;
    logic [7:0] b_req_data, b_rsp_data;

    spi_ram_master #(.RD_LATENCY(RD_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_cmd(a_req_cmd), .req_data(a_req_data), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .busy(a_busy), .SS_n(a_ss_n), .MOSI(a_mosi), .MISO(a_miso)
    );

    spi_ram_master #(.RD_LATENCY(RD_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_cmd(b_req_cmd), .req_data(b_req_data), .rsp_valid(b_rsp_valid),
        .rsp_data(b_rsp_data), .busy(b_busy), .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(b_miso)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wrapper model A: RAM with address register, replies to cmd 11 after RD_A idle cycles.
    logic [7:0]  ram [256];
    logic [7:0]  ram_addr = 8'h00;
    logic [31:0] a_sh = 32'h0, a_last_sh = 32'h0;
    logic [1:0]  a_cmd = 2'b00;
    logic [11:0] a_f;
    int a_k = 0, a_last_len = 0, a_frames = 0, a_rsp_cnt = 0, a_rsp_at = 0, a_high = 0, a_last_gap = 0;

    always @(negedge clk) begin
        if (a_rsp_valid) begin
            a_rsp_cnt++;
            a_rsp_at = a_k;
        end
        if (!a_ss_n) begin
            if (a_k == 0) begin
                a_last_gap = a_high;
                a_sh = 32'h0;
            end
            a_sh = {a_sh[30:0], a_mosi};
            if (a_k == 3) a_cmd = a_sh[1:0];
            if (a_cmd == 2'b11 && a_k >= 12 + RD_A && a_k < 20 + RD_A)
                a_miso = ram[ram_addr][7 - (a_k - 12 - RD_A)];
            else
                a_miso = 1'b0;
            a_k++;
            a_high = 0;
        end else begin
            a_miso = 1'b0;
            a_high++;
            if (a_k != 0) begin
                a_last_len = a_k;
                a_last_sh  = a_sh;
                a_frames++;
                if (a_k >= 12) begin
                    a_f = 12'(a_sh >> (a_k - 12));
                    case (a_f[9:8])
                        2'b00:   ram_addr = a_f[7:0];
                        2'b01:   ram[ram_addr] = a_f[7:0];
                        2'b10:   ram_addr = a_f[7:0];
                        default: ;
                    endcase
                end
                a_k = 0;
                a_cmd = 2'b00;
            end
        end
    end

    // Wrapper model B: always answers 8'h81 with no latency.
    logic [7:0]  b_byte = 8'h81;
    logic [31:0] b_sh = 32'h0, b_last_sh = 32'h0;
    int b_k = 0, b_len = 0, b_rsp_cnt = 0;

    always @(negedge clk) begin
        if (b_rsp_valid) b_rsp_cnt++;
        if (!b_ss_n) begin
            if (b_k == 0) b_sh = 32'h0;
            b_sh = {b_sh[30:0], b_mosi};
            if (b_k >= 12 + RD_B && b_k < 20 + RD_B)
                b_miso = b_byte[7 - (b_k - 12 - RD_B)];
            else
                b_miso = 1'b0;
            b_k++;
        end else begin
            b_miso = 1'b0;
            if (b_k != 0) begin
                b_len = b_k;
                b_last_sh = b_sh;
                b_k = 0;
            end
        end
    end

    task automatic wait_ready_a();
        int t = 0;
        while (!a_req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_val("a_ready_timeout", 32'(t), 32'd0);
    endtask

    task automatic wait_idle_a(output int busy_cyc);
        int t = 0;
        busy_cyc = 0;
        while (a_busy && t < 200) begin
            busy_cyc++;
            @(negedge clk);
            t++;
        end
        if (t >= 200) check_val("a_idle_timeout", 32'(t), 32'd0);
    endtask

    task automatic a_send(input logic [1:0] cmd, input logic [7:0] data, output int busy_cyc);
        wait_ready_a();
        a_req_valid = 1'b1;
        a_req_cmd   = cmd;
        a_req_data  = data;
        @(negedge clk);
        a_req_valid = 1'b0;
        a_req_data  = 8'h00;
        wait_idle_a(busy_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, t, frames0, rsp0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        a_req_valid = 1'b0; a_req_cmd = 2'b00; a_req_data = 8'h00;
        b_req_valid = 1'b0; b_req_cmd = 2'b00; b_req_data = 8'h00;
        a_miso = 1'b0; b_miso = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_ss_n", 32'(a_ss_n), 32'd1);
        check_val("rst_mosi", 32'(a_mosi), 32'd0);
        check_val("rst_ready", 32'(a_req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check_val("rst_rsp_data", 32'(a_rsp_data), 32'h00);
        check_val("rst_busy", 32'(a_busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", 32'(a_req_ready), 32'd1);

        // write address A5
        a_send(2'b00, 8'hA5, bc);
        check_val("wa_mosi", 32'(a_last_sh[11:0]), 32'h0A5);
        check_val("wa_len", 32'(a_last_len), 32'd12);
        check_val("wa_busy", 32'(bc), 32'(12 + GAP_A));
        check_val("wa_no_rsp", 32'(a_rsp_cnt), 32'd0);
        check_val("wa_addr", 32'(ram_addr), 32'hA5);

        // write data 3C
        a_send(2'b01, 8'h3C, bc);
        check_val("wd_mosi", 32'(a_last_sh[11:0]), 32'h13C);
        check_val("wd_mem", 32'(ram[8'hA5]), 32'h3C);
        check_val("wd_no_rsp", 32'(a_rsp_cnt), 32'd0);

        // read address A5, then read data (payload must be sent as zero)
        a_send(2'b10, 8'hA5, bc);
        check_val("ra_mosi", 32'(a_last_sh[11:0]), 32'h6A5);
        a_send(2'b11, 8'h55, bc);
        check_val("rd_mosi", 32'(a_last_sh[20:9]), 32'h700);
        check_val("rd_len", 32'(a_last_len), 32'(20 + RD_A));
        check_val("rd_rsp_cnt", 32'(a_rsp_cnt), 32'd1);
        check_val("rd_rsp_data", 32'(a_rsp_data), 32'h3C);
        check_val("rd_rsp_at", 32'(a_rsp_at), 32'(20 + RD_A));
        check_val("rd_busy", 32'(bc), 32'(20 + RD_A + GAP_A));
        check_val("rd_pulse_low", 32'(a_rsp_valid), 32'd0);

        // req_valid held through a busy frame with a second request
        frames0 = a_frames;
        a_req_valid = 1'b1; a_req_cmd = 2'b00; a_req_data = 8'h5A;
        @(negedge clk);
        a_req_cmd = 2'b01; a_req_data = 8'hFF;
        t = 0;
        while (!a_req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("hold_spacing", 32'(t + 1), 32'(12 + GAP_A + 1));
        @(negedge clk);
        a_req_valid = 1'b0;
        wait_idle_a(bc);
        check_val("hold_frames", 32'(a_frames - frames0), 32'd2);
        check_val("hold_gap", 32'(a_last_gap), 32'(GAP_A + 1));
        check_val("hold_mosi", 32'(a_last_sh[11:0]), 32'h1FF);
        check_val("hold_mem", 32'(ram[8'h5A]), 32'hFF);

        // reset during SHIFT bit 5 of a cmd-11 frame
        rsp0 = a_rsp_cnt;
        a_req_valid = 1'b1; a_req_cmd = 2'b11; a_req_data = 8'h00;
        @(negedge clk);
        a_req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_val("mid_ss_low", 32'(a_ss_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ss_n", 32'(a_ss_n), 32'd1);
        check_val("mid_rst_mosi", 32'(a_mosi), 32'd0);
        check_val("mid_rst_busy", 32'(a_busy), 32'd0);
        check_val("mid_rst_data", 32'(a_rsp_data), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("mid_no_rsp", 32'(a_rsp_cnt - rsp0), 32'd0);
        a_send(2'b00, 8'h10, bc);
        check_val("post_mosi", 32'(a_last_sh[11:0]), 32'h010);
        check_val("post_len", 32'(a_last_len), 32'd12);
        check_val("post_addr", 32'(ram_addr), 32'h10);
        check_val("post_no_rsp", 32'(a_rsp_cnt - rsp0), 32'd0);

        // RD_LATENCY=0 build
        b_req_valid = 1'b1; b_req_cmd = 2'b11; b_req_data = 8'h00;
        t = 0;
        while (!b_req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        bc = 0;
        t = 0;
        while (b_busy && t < 200) begin
            bc++;
            @(negedge clk);
            t++;
        end
        check_val("b_rsp_data", 32'(b_rsp_data), 32'h81);
        check_val("b_len", 32'(b_len), 32'd20);
        check_val("b_mosi", 32'(b_last_sh[19:8]), 32'h700);
        check_val("b_busy", 32'(bc), 32'(20 + GAP_B));
        check_val("b_rsp_cnt", 32'(b_rsp_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
